mem_stage: RTL and testbench

//  MEM stage of the 8-bit pipelined CPU, directly downstream of the EX/MEM register.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage_mem_wb.sv | 20 ++
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit pipelined CPU.
// Used by the MEM stage, its MEM/WB register and the data-memory interface.
package cpu_pkg;

  localparam int DW = 8;
  localparam int RW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic          regWrite;
    logic          overflow;
  } memwb_t;

  // An all-zero writeback slot: nothing is written back.
  function automatic memwb_t memwb_bubble();
    memwb_t b;
    b.data     = {DW{1'b0}};
    b.rd       = {RW{1'b0}};
    b.regWrite = 1'b0;
    b.overflow = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  import cpu_pkg::*;

  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register: captures one writeback slot every cycle.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  memwb_t d,
  output memwb_t q
);

  // Writeback slot register, cleared to a bubble on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= memwb_bubble();
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores over a req/ack bus, stalls upstream while waiting, aborts on timeout.
// Optional feature macro: OVERFLOW_TRAP_EN (suppress writeback and pulse ovf_trap_o on overflow).
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     data_in,
  input  logic              overflow_i,
  input  logic [RW-1:0]     data_rd_i,
  input  logic              memRead_i,
  input  logic              memWrite_i,
  input  logic              regWrite_i,
  input  logic [DW-1:0]     memAddr_i,
  output logic              stall_o,
  mem_stage_if.master       dmem,
  output logic [DW-1:0]     wb_data_o,
  output logic [RW-1:0]     wb_rd_o,
  output logic              wb_regWrite_o,
  output logic              overflow_o,
  output logic              bus_err_o,
  output logic              ovf_trap_o
);

  localparam int CW = $clog2(ACK_TIMEOUT);

  mem_state_t    state_r;
  logic [CW-1:0] cnt_r;
  logic          req_r;
  logic          we_r;
  logic [DW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [RW-1:0] rd_l_r;
  logic          regwrite_l_r;
  logic          ovf_l_r;
  logic          bus_err_r;

  logic          mem_op_s;
  logic          timeout_s;
  logic          stall_s;
  memwb_t        wb_next_s;
  memwb_t        wb_q_s;

  assign mem_op_s  = memRead_i | memWrite_i;
  assign timeout_s = (cnt_r == CW'(ACK_TIMEOUT - 1));

  // Access FSM, wait counter and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= {DW{1'b0}};
      wdata_r      <= {DW{1'b0}};
      rd_l_r       <= {RW{1'b0}};
      regwrite_l_r <= 1'b0;
      ovf_l_r      <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            state_r      <= WAIT;
            cnt_r        <= {CW{1'b0}};
            req_r        <= 1'b1;
            // A simultaneous read and write request is treated as a load.
            we_r         <= memWrite_i & ~memRead_i;
            addr_r       <= memAddr_i;
            wdata_r      <= data_in;
            rd_l_r       <= data_rd_i;
            regwrite_l_r <= regWrite_i;
            ovf_l_r      <= overflow_i;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (dmem.ack) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
          end else if (timeout_s) begin
            state_r   <= IDLE;
            req_r     <= 1'b0;
            bus_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Stall decision and next MEM/WB slot; ack beats a same-cycle timeout.
  always_comb begin
    wb_next_s = memwb_bubble();
    stall_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          stall_s = 1'b1;
        end else begin
          wb_next_s.data     = data_in;
          wb_next_s.rd       = data_rd_i;
          wb_next_s.regWrite = regWrite_i;
          wb_next_s.overflow = overflow_i;
        end
      end
      WAIT: begin
        if (dmem.ack) begin
          stall_s            = 1'b0;
          wb_next_s.data     = we_r ? {DW{1'b0}} : dmem.rdata;
          wb_next_s.rd       = rd_l_r;
          wb_next_s.regWrite = regwrite_l_r & ~we_r;
          wb_next_s.overflow = ovf_l_r;
        end else if (timeout_s) begin
          stall_s = 1'b0;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  memwb_t wb_gated_s;
  logic   trap_s;
  logic   trap_r;

  // An overflowing instruction that would write rd traps instead of writing.
  always_comb begin
    wb_gated_s = wb_next_s;
    trap_s     = 1'b0;
    if (wb_next_s.regWrite && wb_next_s.overflow) begin
      wb_gated_s.regWrite = 1'b0;
      trap_s              = 1'b1;
    end else begin
      trap_s = 1'b0;
    end
  end

  // Trap pulse aligned with the writeback slot it replaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= trap_s;
    end
  end

  assign ovf_trap_o = trap_r;

  mem_wb_reg u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wb_gated_s),
    .q     (wb_q_s)
  );
`else
  assign ovf_trap_o = 1'b0;

  mem_wb_reg u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wb_next_s),
    .q     (wb_q_s)
  );
`endif

  // Stall is forced low while reset is asserted so upstream sees a quiet pipe.
  assign stall_o       = stall_s & rst_n;
  assign dmem.req      = req_r;
  assign dmem.we       = we_r;
  assign dmem.addr     = addr_r;
  assign dmem.wdata    = wdata_r;
  assign wb_data_o     = wb_q_s.data;
  assign wb_rd_o       = wb_q_s.rd;
  assign wb_regWrite_o = wb_q_s.regWrite;
  assign overflow_o    = wb_q_s.overflow;
  assign bus_err_o     = bus_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: models upstream issue and a data memory with per-op ack delay.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       overflow_in;
  logic [2:0] data_rd;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [7:0] mem_addr;
  logic       stall_o;
  logic [7:0] wb_data_o;
  logic [2:0] wb_rd_o;
  logic       wb_regWrite_o;
  logic       overflow_o;
  logic       bus_err_o;
  logic       ovf_trap_o;

  mem_stage_if dmem ();

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .overflow_i    (overflow_in),
    .data_rd_i     (data_rd),
    .memRead_i     (mem_read),
    .memWrite_i    (mem_write),
    .regWrite_i    (reg_write),
    .memAddr_i     (mem_addr),
    .stall_o       (stall_o),
    .dmem          (dmem.master),
    .wb_data_o     (wb_data_o),
    .wb_rd_o       (wb_rd_o),
    .wb_regWrite_o (wb_regWrite_o),
    .overflow_o    (overflow_o),
    .bus_err_o     (bus_err_o),
    .ovf_trap_o    (ovf_trap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
    logic       ovf;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  wb_exp_t mon_e;
  int      err_pend  = 0;
  int      trap_pend = 0;
  int      n_cmp     = 0;
  int      n_err     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic [7:0] d, input logic [2:0] rd, input logic ovf);
`ifdef OVERFLOW_TRAP_EN
    if (ovf) trap_pend++;
    else wb_q.push_back('{data: d, rd: rd, ovf: ovf});
`else
    wb_q.push_back('{data: d, rd: rd, ovf: ovf});
`endif
  endtask

  // Scoreboard side: every writeback, bus error and trap must have been predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_regWrite_o) begin
        check_eq("wb_expected", 32'(wb_q.size() > 0), 32'd1);
        if (wb_q.size() > 0) begin
          mon_e = wb_q.pop_front();
          check_eq("wb_data", wb_data_o, mon_e.data);
          check_eq("wb_rd", wb_rd_o, mon_e.rd);
          check_eq("wb_ovf", overflow_o, mon_e.ovf);
        end
      end
      if (bus_err_o) begin
        check_eq("bus_err_expected", 32'(err_pend > 0), 32'd1);
        if (err_pend > 0) err_pend--;
      end
      if (ovf_trap_o) begin
        check_eq("trap_expected", 32'(trap_pend > 0), 32'd1);
        if (trap_pend > 0) trap_pend--;
      end
    end
  end

  task automatic set_nop();
    data_in     = 8'h00;
    overflow_in = 1'b0;
    data_rd     = 3'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_addr    = 8'h00;
  endtask

  // Issue one instruction and hold it until the stage accepts it; ack_dly < 0 means never ack.
  task automatic run_op(input string tag, input logic rd_en, input logic wr_en, input logic rw,
                        input logic ovf, input logic [7:0] din, input logic [7:0] addr,
                        input logic [7:0] rdata, input logic [2:0] rd, input int ack_dly);
    int  stalls = 0;
    int  waits  = 0;
    bit  done   = 1'b0;
    bit  is_mem = rd_en | wr_en;
    bit  will_ack = (ack_dly >= 0) && (ack_dly < TO);
    bit  is_store = wr_en & ~rd_en;
    int  exp_stall;
    if (!is_mem) begin
      exp_stall = 0;
      if (rw) push_wb(din, rd, ovf);
    end else if (will_ack) begin
      exp_stall = ack_dly + 1;
      if (rd_en && rw) push_wb(rdata, rd, ovf);
    end else begin
      exp_stall = TO;
      err_pend++;
    end
    @(negedge clk);
    data_in = din; overflow_in = ovf; data_rd = rd; mem_read = rd_en;
    mem_write = wr_en; reg_write = rw; mem_addr = addr;
    for (int cyc = 0; cyc < TO + 8 && !done; cyc++) begin
      if (dmem.req) begin
        check_eq({tag, "_we"}, dmem.we, is_store);
        check_eq({tag, "_addr"}, dmem.addr, addr);
        if (is_store) check_eq({tag, "_wdata"}, dmem.wdata, din);
        if (waits == ack_dly) begin
          dmem.ack   = 1'b1;
          dmem.rdata = rdata;
        end
        waits++;
      end
      #1;
      if (stall_o) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      dmem.ack   = 1'b0;
      dmem.rdata = 8'h00;
      if (!done) @(negedge clk);
    end
    set_nop();
    check_eq({tag, "_accepted"}, 32'(done), 32'd1);
    check_eq({tag, "_stalls"}, stalls, exp_stall);
    check_eq({tag, "_req_cycles"}, waits, is_mem ? exp_stall : 0);
    if (is_mem) check_eq({tag, "_req_drop"}, dmem.req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    dmem.ack   = 1'b0;
    dmem.rdata = 8'h00;
    set_nop();
    mem_read   = 1'b1;
    #1;
    check_eq("rst_stall", stall_o, 1'b0);
    check_eq("rst_req", dmem.req, 1'b0);
    check_eq("rst_wb_we", wb_regWrite_o, 1'b0);
    check_eq("rst_wb_data", wb_data_o, 8'h00);
    check_eq("rst_bus_err", bus_err_o, 1'b0);
    check_eq("rst_trap", ovf_trap_o, 1'b0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("alu",        1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 3'd5, -1);
    run_op("load",       1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'hA5, 3'd3, 3);
    run_op("store",      1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h10, 8'h00, 3'd0, 0);
    run_op("store_rw",   1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h11, 8'hFF, 3'd6, 1);
    run_op("load_to",    1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h30, 8'hEE, 3'd4, -1);
    run_op("load_ack15", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h31, 8'hC3, 3'd4, TO - 1);
    run_op("store_to",   1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 8'h40, 8'h00, 3'd2, -1);
    run_op("rdwr",       1'b1, 1'b1, 1'b1, 1'b0, 8'hAB, 8'h50, 8'h5C, 3'd7, 2);
    run_op("alu_ovf",    1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 8'h00, 8'h00, 3'd2, -1);
    run_op("load_ovf",   1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h60, 8'h7E, 3'd1, 0);
    run_op("alu_nowr",   1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 3'd3, -1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      run_op("alu_b2b", 1'b0, 1'b0, 1'b1, 1'b0, d, 8'h00, 8'h00, 3'(i), -1);
    end

    // Async reset in the middle of a load: request and stall must drop at once, no writeback.
    @(negedge clk);
    mem_read = 1'b1; reg_write = 1'b1; data_rd = 3'd1; mem_addr = 8'h44;
    @(negedge clk);
    check_eq("rst_mid_req_before", dmem.req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", dmem.req, 1'b0);
    check_eq("rst_mid_stall", stall_o, 1'b0);
    check_eq("rst_mid_addr", dmem.addr, 8'h00);
    check_eq("rst_mid_wb_we", wb_regWrite_o, 1'b0);
    check_eq("rst_mid_bus_err", bus_err_o, 1'b0);
    @(negedge clk);
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_rel_req", dmem.req, 1'b0);
    run_op("alu_after_rst", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5E, 8'h00, 8'h00, 3'd6, -1);
    run_op("load_after_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h21, 8'h3D, 3'd2, 1);

    repeat (3) @(negedge clk);
    check_eq("wb_queue_empty", wb_q.size(), 0);
    check_eq("bus_err_all_seen", err_pend, 0);
    check_eq("trap_all_seen", trap_pend, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
